// File: rtl/conditioner_pkg.sv
// rtl/conditioner_pkg.sv - shared edge-mode constants and width helper for input_conditioner
package conditioner_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Ceiling log2, never less than 1 so a one-channel index still has a bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/channel_debouncer.sv
// rtl/channel_debouncer.sv - one channel: synchroniser, debounce counter, edge qualifier
module channel_debouncer
    import conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 16,
    parameter int   EDGE_MODE   = EDGE_RISE,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic edge_pulse
);

    localparam int               CNT_W    = clog2_min1(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   edge_q;
    logic                   edge_d;
    logic                   synced;
    logic                   flip;
    logic                   dir_ok;

    assign synced     = sync_q[SYNC_STAGES-1];
    assign level_out  = level_q;
    assign edge_pulse = edge_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
        cnt_d   = cnt_q;
        level_d = level_q;
        flip    = 1'b0;
        // Any cycle where the synced value agrees with the output restarts the count.
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            flip    = 1'b1;
            level_d = synced;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (EDGE_MODE)
            EDGE_RISE: dir_ok = synced;
            EDGE_FALL: dir_ok = ~synced;
            default:   dir_ok = 1'b1;
        endcase
        edge_d = flip & dir_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            edge_q  <= edge_d;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel debounced edge events with MSB-first valid/ack
module input_conditioner
    import conditioner_pkg::*;
#(
    parameter int   CH          = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 16,
    parameter int   EDGE_MODE   = EDGE_RISE,
    parameter logic RESET_LEVEL = 1'b0,
    localparam int  IDX_W       = clog2_min1(CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    raw_in,
    output logic [CH-1:0]    level_out,
    output logic [CH-1:0]    edge_pulse,
    output logic             event_valid,
    output logic [CH-1:0]    event_onehot,
    output logic [IDX_W-1:0] event_index,
    input  logic             event_ack,
    output logic             overflow,
    input  logic             overflow_clr
);

    logic [CH-1:0] edge_vec;
    logic [CH-1:0] pending_q;
    logic [CH-1:0] pending_d;
    logic [CH-1:0] clear;
    logic          overflow_q;
    logic          overflow_d;
    logic          merge;

    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_ch
            channel_debouncer #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE    (DEBOUNCE),
                .EDGE_MODE   (EDGE_MODE),
                .RESET_LEVEL (RESET_LEVEL)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .raw_in     (raw_in[g]),
                .level_out  (level_out[g]),
                .edge_pulse (edge_vec[g])
            );
        end
    endgenerate

    assign edge_pulse  = edge_vec;
    assign event_valid = |pending_q;
    assign overflow    = overflow_q;

    // Ascending scan so the highest pending index is the last one written.
    always_comb begin
        event_onehot = '0;
        event_index  = '0;
        for (int i = 0; i < CH; i++) begin
            if (pending_q[i]) begin
                event_onehot    = '0;
                event_onehot[i] = 1'b1;
                event_index     = IDX_W'(i);
            end
        end
    end

    always_comb begin
        clear      = (event_valid && event_ack) ? event_onehot : '0;
        pending_d  = (pending_q & ~clear) | edge_vec;
        merge      = |(edge_vec & pending_q & ~clear);
        overflow_d = merge | (overflow_q & ~overflow_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;
    import conditioner_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [3:0] raw_a = 4'h0, lvl_a, pulse_a, onehot_a;
    logic [1:0] index_a;
    logic       valid_a, ack_a = 1'b0, ovf_a, clr_a = 1'b0;

    logic [3:0] raw_b = 4'h0, lvl_b, pulse_b, onehot_b;
    logic [1:0] index_b;
    logic       valid_b, ack_b = 1'b0, ovf_b, clr_b = 1'b0;

    logic [3:0] raw_c = 4'hF, lvl_c, pulse_c, onehot_c;
    logic [1:0] index_c;
    logic       valid_c, ack_c = 1'b0, ovf_c, clr_c = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_conditioner #(.CH(4), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_MODE(EDGE_RISE), .RESET_LEVEL(1'b0)) dut_rise (
        .clk(clk), .rst(rst), .raw_in(raw_a), .level_out(lvl_a), .edge_pulse(pulse_a),
        .event_valid(valid_a), .event_onehot(onehot_a), .event_index(index_a),
        .event_ack(ack_a), .overflow(ovf_a), .overflow_clr(clr_a));

    input_conditioner #(.CH(4), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_MODE(EDGE_BOTH), .RESET_LEVEL(1'b0)) dut_both (
        .clk(clk), .rst(rst), .raw_in(raw_b), .level_out(lvl_b), .edge_pulse(pulse_b),
        .event_valid(valid_b), .event_onehot(onehot_b), .event_index(index_b),
        .event_ack(ack_b), .overflow(ovf_b), .overflow_clr(clr_b));

    input_conditioner #(.CH(4), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_MODE(EDGE_FALL), .RESET_LEVEL(1'b1)) dut_fall (
        .clk(clk), .rst(rst), .raw_in(raw_c), .level_out(lvl_c), .edge_pulse(pulse_c),
        .event_valid(valid_c), .event_onehot(onehot_c), .event_index(index_c),
        .event_ack(ack_c), .overflow(ovf_c), .overflow_clr(clr_c));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] seen_p;
        logic       seen_v;
        rst = 1'b1;
        tick(2);
        checks++; if (lvl_a !== 4'b0000) begin errors++; $display("FAIL rst_level got=%b exp=0000", lvl_a); end
        checks++; if (pulse_a !== 4'b0000) begin errors++; $display("FAIL rst_pulse got=%b exp=0000", pulse_a); end
        checks++; if ({valid_a, onehot_a, index_a, ovf_a} !== 8'b0) begin errors++; $display("FAIL rst_event got=%b exp=0", {valid_a, onehot_a, index_a, ovf_a}); end
        checks++; if (lvl_c !== 4'b1111) begin errors++; $display("FAIL rst_level_hi got=%b exp=1111", lvl_c); end
        rst = 1'b0;
        seen_p = '0; seen_v = 1'b0;
        repeat (8) begin
            tick(1);
            seen_p |= pulse_a | pulse_b | pulse_c;
            seen_v |= valid_a | valid_b | valid_c;
        end
        checks++; if ({seen_p, seen_v} !== 5'b0) begin errors++; $display("FAIL rst_release_quiet got=%b exp=0", {seen_p, seen_v}); end
    endtask

    task automatic test_rise_event();
        logic [3:0] seen_p;
        logic       seen_v;
        raw_a[0] = 1'b1;
        tick(5);
        checks++; if (lvl_a !== 4'b0000) begin errors++; $display("FAIL t1_level_edge5 got=%b exp=0000", lvl_a); end
        tick(1);
        checks++; if (lvl_a !== 4'b0001) begin errors++; $display("FAIL t1_level_edge6 got=%b exp=0001", lvl_a); end
        checks++; if (pulse_a !== 4'b0001) begin errors++; $display("FAIL t1_pulse got=%b exp=0001", pulse_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t1_valid_early got=%b exp=0", valid_a); end
        tick(1);
        checks++; if (pulse_a !== 4'b0000) begin errors++; $display("FAIL t1_pulse_len got=%b exp=0000", pulse_a); end
        checks++; if ({valid_a, onehot_a, index_a} !== 7'b1_0001_00) begin errors++; $display("FAIL t1_event got=%b exp=1000100", {valid_a, onehot_a, index_a}); end
        ack_a = 1'b1;
        tick(1);
        ack_a = 1'b0;
        checks++; if ({valid_a, onehot_a, index_a} !== 7'b0) begin errors++; $display("FAIL t1_ack got=%b exp=0", {valid_a, onehot_a, index_a}); end
        raw_a[0] = 1'b0;
        seen_p = '0; seen_v = 1'b0;
        repeat (8) begin
            tick(1);
            seen_p |= pulse_a;
            seen_v |= valid_a;
        end
        checks++; if (lvl_a !== 4'b0000) begin errors++; $display("FAIL t1_fall_level got=%b exp=0000", lvl_a); end
        checks++; if ({seen_p, seen_v} !== 5'b0) begin errors++; $display("FAIL t1_fall_no_event got=%b exp=0", {seen_p, seen_v}); end
    endtask

    task automatic test_glitch_reject();
        logic [3:0] seen_l, seen_p;
        logic       seen_v;
        raw_a[2] = 1'b1;
        tick(3);
        raw_a[2] = 1'b0;
        seen_l = '0; seen_p = '0; seen_v = 1'b0;
        repeat (8) begin
            tick(1);
            seen_l |= lvl_a;
            seen_p |= pulse_a;
            seen_v |= valid_a;
        end
        checks++; if ({seen_l, seen_p, seen_v} !== 9'b0) begin errors++; $display("FAIL t2_short_pulse got=%b exp=0", {seen_l, seen_p, seen_v}); end
        raw_a[2] = 1'b1;
        tick(4);
        raw_a[2] = 1'b0;
        tick(2);
        checks++; if ({lvl_a, pulse_a} !== 8'b0100_0100) begin errors++; $display("FAIL t2_min_pulse got=%b exp=01000100", {lvl_a, pulse_a}); end
        tick(6);
        checks++; if ({lvl_a, valid_a, onehot_a, index_a} !== 11'b0000_1_0100_10) begin errors++; $display("FAIL t2_min_event got=%b exp=00001010010", {lvl_a, valid_a, onehot_a, index_a}); end
        ack_a = 1'b1;
        tick(1);
        ack_a = 1'b0;
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t2_ack got=%b exp=0", valid_a); end
    endtask

    task automatic test_priority();
        raw_a = 4'b1010;
        tick(6);
        checks++; if ({lvl_a, pulse_a} !== 8'b1010_1010) begin errors++; $display("FAIL t3_flip got=%b exp=10101010", {lvl_a, pulse_a}); end
        tick(1);
        checks++; if ({valid_a, onehot_a, index_a} !== 7'b1_1000_11) begin errors++; $display("FAIL t3_first got=%b exp=1100011", {valid_a, onehot_a, index_a}); end
        ack_a = 1'b1;
        tick(1);
        checks++; if ({valid_a, onehot_a, index_a} !== 7'b1_0010_01) begin errors++; $display("FAIL t3_second got=%b exp=1001001", {valid_a, onehot_a, index_a}); end
        tick(1);
        ack_a = 1'b0;
        checks++; if ({valid_a, onehot_a, index_a} !== 7'b0) begin errors++; $display("FAIL t3_drained got=%b exp=0", {valid_a, onehot_a, index_a}); end
        raw_a = 4'b0000;
        tick(8);
        checks++; if ({lvl_a, valid_a} !== 5'b0) begin errors++; $display("FAIL t3_idle got=%b exp=0", {lvl_a, valid_a}); end
    endtask

    task automatic test_overflow();
        raw_b[2] = 1'b1;
        tick(6);
        checks++; if ({lvl_b, pulse_b} !== 8'b0100_0100) begin errors++; $display("FAIL t4_rise got=%b exp=01000100", {lvl_b, pulse_b}); end
        tick(1);
        checks++; if ({valid_b, onehot_b, ovf_b} !== 6'b1_0100_0) begin errors++; $display("FAIL t4_pending got=%b exp=101000", {valid_b, onehot_b, ovf_b}); end
        raw_b[2] = 1'b0;
        tick(6);
        checks++; if ({lvl_b, pulse_b, ovf_b} !== 9'b0000_0100_0) begin errors++; $display("FAIL t4_fall got=%b exp=000001000", {lvl_b, pulse_b, ovf_b}); end
        tick(1);
        checks++; if ({ovf_b, valid_b, onehot_b} !== 6'b1_1_0100) begin errors++; $display("FAIL t4_overflow got=%b exp=110100", {ovf_b, valid_b, onehot_b}); end
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        checks++; if ({ovf_b, valid_b} !== 2'b01) begin errors++; $display("FAIL t4_clr got=%b exp=01", {ovf_b, valid_b}); end
        raw_b[2] = 1'b1;
        tick(6);
        checks++; if (pulse_b !== 4'b0100) begin errors++; $display("FAIL t4_rise2 got=%b exp=0100", pulse_b); end
        ack_b = 1'b1;
        tick(1);
        ack_b = 1'b0;
        checks++; if ({valid_b, onehot_b, ovf_b} !== 6'b1_0100_0) begin errors++; $display("FAIL t4_ack_coincide got=%b exp=101000", {valid_b, onehot_b, ovf_b}); end
        raw_b[2] = 1'b0;
        tick(6);
        checks++; if (pulse_b !== 4'b0100) begin errors++; $display("FAIL t4_fall2 got=%b exp=0100", pulse_b); end
        clr_b = 1'b1;
        tick(1);
        checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL t4_set_wins got=%b exp=1", ovf_b); end
        tick(1);
        clr_b = 1'b0;
        checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL t4_clr2 got=%b exp=0", ovf_b); end
        ack_b = 1'b1;
        tick(1);
        ack_b = 1'b0;
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL t4_drain got=%b exp=0", valid_b); end
    endtask

    task automatic test_reset_midcount();
        logic [3:0] seen_l, seen_p;
        logic       seen_v;
        raw_a = 4'b1000;
        tick(7);
        checks++; if ({lvl_a, valid_a} !== 5'b1000_1) begin errors++; $display("FAIL t5_setup got=%b exp=10001", {lvl_a, valid_a}); end
        raw_a = 4'b0001;
        tick(3);
        raw_a = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({lvl_a, pulse_a, valid_a, onehot_a, index_a, ovf_a} !== 16'b0) begin errors++; $display("FAIL t5_async got=%b exp=0", {lvl_a, pulse_a, valid_a, onehot_a, index_a, ovf_a}); end
        tick(2);
        rst = 1'b0;
        seen_l = '0; seen_p = '0; seen_v = 1'b0;
        repeat (10) begin
            tick(1);
            seen_l |= lvl_a;
            seen_p |= pulse_a;
            seen_v |= valid_a;
        end
        checks++; if ({seen_l, seen_p, seen_v} !== 9'b0) begin errors++; $display("FAIL t5_after got=%b exp=0", {seen_l, seen_p, seen_v}); end
    endtask

    task automatic test_fall_mode();
        raw_c[0] = 1'b0;
        tick(6);
        checks++; if ({lvl_c, pulse_c} !== 8'b1110_0001) begin errors++; $display("FAIL t6_fall got=%b exp=11100001", {lvl_c, pulse_c}); end
        tick(1);
        checks++; if ({valid_c, onehot_c, index_c} !== 7'b1_0001_00) begin errors++; $display("FAIL t6_event got=%b exp=1000100", {valid_c, onehot_c, index_c}); end
        ack_c = 1'b1;
        tick(1);
        ack_c = 1'b0;
        checks++; if (valid_c !== 1'b0) begin errors++; $display("FAIL t6_ack got=%b exp=0", valid_c); end
        raw_c[0] = 1'b1;
        tick(6);
        checks++; if ({lvl_c, pulse_c} !== 8'b1111_0000) begin errors++; $display("FAIL t6_rise got=%b exp=11110000", {lvl_c, pulse_c}); end
        tick(1);
        checks++; if (valid_c !== 1'b0) begin errors++; $display("FAIL t6_no_event got=%b exp=0", valid_c); end
    endtask

    initial begin
        test_reset();
        test_rise_event();
        test_glitch_reject();
        test_priority();
        test_overflow();
        test_reset_midcount();
        test_fall_mode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
